// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate sequencer.
package parking_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_OPEN   = 2'd2,
    S_STROBE = 2'd3
  } state_t;

  localparam logic [1:0] ENTRY0 = 2'd0;
  localparam logic [1:0] ENTRY1 = 2'd1;
  localparam logic [1:0] EXIT0  = 2'd2;
  localparam logic [1:0] EXIT1  = 2'd3;

  localparam int unsigned STROBE_LEN_DEF   = 4;
  localparam int unsigned OPEN_TIMEOUT_DEF = 1000;

  function automatic logic is_entry(input logic [1:0] lane);
    return lane < EXIT0;
  endfunction

endpackage

// File: rtl/gate_sequencer_if.sv
// Per-lane request/sensor/barrier signals between the lane hardware and the sequencer.
interface gate_sequencer_if;
  logic [3:0] req;
  logic [3:0] req_uni;
  logic [3:0] passed;
  logic [3:0] gate_open;
  logic [3:0] reject;

  modport master (
    output req, req_uni, passed,
    input  gate_open, reject
  );

  modport slave (
    input  req, req_uni, passed,
    output gate_open, reject
  );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin pick: first requesting lane at or after ptr, wrapping.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] grant,
  output logic [1:0] idx
);

  logic       found;
  logic [1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = ptr + i[1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    grant = found ? (4'b0001 << idx) : '0;
  end

endmodule

// File: rtl/gate_sequencer.sv
// Serves one parking lane at a time: space check, barrier open with timeout,
// then a fixed-length count strobe for the occupancy datapath.
module gate_sequencer
  import parking_pkg::*;
#(
  parameter int unsigned STROBE_LEN   = STROBE_LEN_DEF,
  parameter int unsigned OPEN_TIMEOUT = OPEN_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             uni_space,
  input  logic             other_space,
  gate_sequencer_if.slave  lanes,
  output logic             car_entered,
  output logic             is_uni_car_entered,
  output logic             car_exited,
  output logic             is_uni_car_exited,
  output logic             timeout_err,
  output logic             busy
);

  // One timer serves both the open window and the strobe length.
  localparam int unsigned TMAX = (OPEN_TIMEOUT > STROBE_LEN) ? OPEN_TIMEOUT : STROBE_LEN;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_t        state, state_d;
  logic [1:0]    lane, lane_d;
  logic          uni, uni_d;
  logic [1:0]    ptr, ptr_d;
  logic [TW-1:0] timer, timer_d;
  logic [3:0]    reject_q, reject_d;
  logic          timeout_q, timeout_d;

  logic [3:0]    grant_oh;
  logic [1:0]    grant_idx;
  logic [3:0]    lane_oh;
  logic          space_ok;

  rr_arbiter4 u_arb (
    .req   (lanes.req),
    .ptr   (ptr),
    .grant (grant_oh),
    .idx   (grant_idx)
  );

  assign lane_oh  = 4'b0001 << lane;
  assign space_ok = uni ? uni_space : other_space;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      lane      <= '0;
      uni       <= 1'b0;
      ptr       <= '0;
      timer     <= '0;
      reject_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_d;
      lane      <= lane_d;
      uni       <= uni_d;
      ptr       <= ptr_d;
      timer     <= timer_d;
      reject_q  <= reject_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state;
    lane_d    = lane;
    uni_d     = uni;
    ptr_d     = ptr;
    timer_d   = timer;
    reject_d  = '0;
    timeout_d = 1'b0;

    if (!enable) begin
      state_d = S_IDLE;
      timer_d = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (|lanes.req) begin
            lane_d  = grant_idx;
            uni_d   = |(lanes.req_uni & grant_oh);
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (is_entry(lane) && !space_ok) begin
            reject_d = lane_oh;
            ptr_d    = lane + 2'd1;
            state_d  = S_IDLE;
          end else begin
            timer_d = '0;
            state_d = S_OPEN;
          end
        end
        // A pass in the final timeout cycle still wins over the timeout.
        S_OPEN: begin
          if (lanes.passed[lane]) begin
            timer_d = '0;
            ptr_d   = lane + 2'd1;
            state_d = S_STROBE;
          end else if (timer == TW'(OPEN_TIMEOUT - 1)) begin
            timer_d   = '0;
            timeout_d = 1'b1;
            ptr_d     = lane + 2'd1;
            state_d   = S_IDLE;
          end else begin
            timer_d = timer + 1'b1;
          end
        end
        S_STROBE: begin
          if (timer == TW'(STROBE_LEN - 1)) begin
            timer_d = '0;
            state_d = S_IDLE;
          end else begin
            timer_d = timer + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    lanes.gate_open    = (state == S_OPEN) ? lane_oh : '0;
    lanes.reject       = reject_q;
    timeout_err        = timeout_q;
    busy               = (state != S_IDLE);
    car_entered        = (state == S_STROBE) && is_entry(lane);
    car_exited         = (state == S_STROBE) && !is_entry(lane);
    is_uni_car_entered = car_entered && uni;
    is_uni_car_exited  = car_exited && uni;
  end

endmodule

// File: tb/tb_gate_sequencer.sv
// Transaction-level model expands each lane service into a per-cycle timeline
// of stimulus and expected outputs; one process replays it and compares.
module tb_gate_sequencer;

  localparam int SL = 4;
  localparam int OT = 16;

  logic clk = 1'b0;
  logic reset_n, enable, uni_space, other_space;
  logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic timeout_err, busy;

  gate_sequencer_if lanes ();

  gate_sequencer #(.STROBE_LEN(SL), .OPEN_TIMEOUT(OT)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .enable             (enable),
    .uni_space          (uni_space),
    .other_space        (other_space),
    .lanes              (lanes),
    .car_entered        (car_entered),
    .is_uni_car_entered (is_uni_car_entered),
    .car_exited         (car_exited),
    .is_uni_car_exited  (is_uni_car_exited),
    .timeout_err        (timeout_err),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  // exp = {gate[3:0], reject[3:0], timeout, ce, ce_uni, cx, cx_uni, busy}
  typedef struct {
    logic        en;
    logic        rst;
    logic        us;
    logic        os;
    logic [3:0]  req;
    logic [3:0]  uni;
    logic [3:0]  pas;
    logic [13:0] exp;
  } step_t;

  step_t q[$];
  int    mptr = 0;
  int    n_chk = 0;
  int    n_fail = 0;

  function automatic logic [13:0] pk(logic [3:0] g, logic [3:0] r, logic to, logic ce,
                                     logic cu, logic cx, logic xu, logic b);
    return {g, r, to, ce, cu, cx, xu, b};
  endfunction

  function automatic step_t mk(logic en, logic [3:0] req, logic us, logic os,
                               logic [3:0] pas, logic [13:0] e);
    step_t s;
    s.en  = en;
    s.rst = 1'b0;
    s.us  = us;
    s.os  = os;
    s.req = req;
    s.uni = 4'($urandom);
    s.pas = pas;
    s.exp = e;
    return s;
  endfunction

  function automatic int pick(logic [3:0] r, int p);
    for (int i = 0; i < 4; i++)
      if (r[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic gap(input int n, input logic [3:0] rej, input logic to);
    for (int i = 0; i < n; i++) begin
      logic en;
      en = ($urandom_range(0, 3) != 0);
      q.push_back(mk(en, en ? 4'd0 : 4'($urandom), 1'($urandom), 1'($urandom),
                     4'($urandom), (i == 0) ? pk(4'd0, rej, to, 0, 0, 0, 0, 0) : 14'd0));
    end
  endtask

  // One service from an IDLE cycle holding req. pass_at = open cycle (1-based) in
  // which the granted lane reports a pass; beyond OT means never.
  task automatic txn(input logic [3:0] req, input logic [3:0] uni, input logic us,
                     input logic os, input int pass_at, input int drop_at,
                     input int rst_at, output int lane, output int st);
    step_t      s;
    logic [3:0] oh, pas;
    logic       u, entry, pass;
    int         n;
    lane  = pick(req, mptr);
    oh    = 4'b0001 << lane;
    u     = uni[lane];
    entry = (lane < 2);
    st    = q.size();
    s = mk(1'b1, req, us, os, 4'($urandom), 14'd0);
    s.uni = uni;
    q.push_back(s);
    q.push_back(mk(1'b1, 4'($urandom), us, os, 4'($urandom) & ~oh, pk(0, 0, 0, 0, 0, 0, 0, 1)));
    if (entry && !(u ? us : os)) begin
      mptr = (lane + 1) % 4;
      gap($urandom_range(1, 3), oh, 1'b0);
      return;
    end
    pass = (pass_at <= OT);
    n    = pass ? pass_at : OT;
    for (int k = 0; k < n; k++) begin
      pas = 4'($urandom) & ~oh;
      if (pass && k == n - 1) pas = pas | oh;
      q.push_back(mk((drop_at == k) ? 1'b0 : 1'b1, 4'($urandom), us, os, pas,
                     pk(oh, 0, 0, 0, 0, 0, 0, 1)));
      if (drop_at == k) begin
        gap($urandom_range(1, 3), 4'd0, 1'b0);
        return;
      end
    end
    mptr = (lane + 1) % 4;
    if (!pass) begin
      gap($urandom_range(1, 3), 4'd0, 1'b1);
      return;
    end
    for (int k = 0; k < SL; k++) begin
      s = mk(1'b1, 4'($urandom), us, os, 4'($urandom),
             pk(0, 0, 0, entry, entry & u, !entry, !entry & u, 1));
      s.rst = (rst_at == k);
      q.push_back(s);
      if (rst_at == k) begin
        mptr = 0;
        gap($urandom_range(1, 3), 4'd0, 1'b0);
        return;
      end
    end
    gap($urandom_range(1, 3), 4'd0, 1'b0);
  endtask

  function automatic int count(int st, int hi, int lo, logic [13:0] want);
    int c = 0;
    for (int i = st; i < q.size(); i++)
      if ((q[i].exp >> lo) % (1 << (hi - lo + 1)) == want) c++;
    return c;
  endfunction

  logic [13:0] got;

  initial begin
    int lane, st, r;
    int ord[5];
    ord = '{0, 1, 2, 3, 0};

    // Directed services, pinned against hand-derived numbers.
    txn(4'b0001, 4'b0001, 1'b1, 1'b0, 5, -1, -1, lane, st);
    chk("e0_lane", lane, 0);
    chk("e0_gate_cycles", count(st, 13, 10, 14'b0001), 5);
    chk("e0_uni_strobe_cycles", count(st, 4, 3, 14'b11), 4);

    txn(4'b0010, 4'b0000, 1'b1, 1'b0, 3, -1, -1, lane, st);
    r = -1;
    for (int i = q.size() - 1; i >= st; i--) if (q[i].exp[9:6] == 4'b0010) r = i;
    chk("e1_reject_delay", r - st, 2);
    chk("e1_no_gate", count(st, 13, 10, 14'b0010), 0);

    txn(4'b0100, 4'b0100, 1'b1, 1'b1, 2, -1, 1, lane, st);
    chk("rst_lane", lane, 2);
    chk("rst_ptr", mptr, 0);

    for (int i = 0; i < 5; i++) begin
      txn(4'b1111, 4'($urandom), 1'b1, 1'b1, 1, -1, -1, lane, st);
      chk($sformatf("rr_order_%0d", i), lane, ord[i]);
    end

    txn(4'b0100, 4'b0000, 1'b1, 1'b1, OT + 5, -1, -1, lane, st);
    chk("to_lane", lane, 2);
    chk("to_gate_cycles", count(st, 13, 10, 14'b0100), OT);
    chk("to_pulses", count(st, 5, 5, 14'b1), 1);
    chk("to_no_strobe", count(st, 2, 2, 14'b1), 0);

    txn(4'b1000, 4'b0000, 1'b1, 1'b1, 10, 3, -1, lane, st);
    chk("drop_gate_cycles", count(st, 13, 10, 14'b1000), 4);
    txn(4'b1001, 4'b1000, 1'b1, 1'b1, OT, -1, -1, lane, st);
    chk("drop_ptr_held_lane", lane, 3);
    chk("edge_pass_strobe", count(st, 1, 1, 14'b1), SL);

    for (int t = 0; t < 40; t++)
      txn(4'($urandom_range(1, 15)), 4'($urandom), 1'($urandom), 1'($urandom),
          $urandom_range(1, OT + 2),
          ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1,
          ($urandom_range(0, 9) == 0) ? $urandom_range(0, SL - 1) : -1, lane, st);

    reset_n     = 1'b0;
    enable      = 1'b0;
    uni_space   = 1'b0;
    other_space = 1'b0;
    lanes.req     = '0;
    lanes.req_uni = '0;
    lanes.passed  = '0;
    repeat (3) @(posedge clk);
    #1;
    got = pk(lanes.gate_open, lanes.reject, timeout_err, car_entered, is_uni_car_entered,
             car_exited, is_uni_car_exited, busy);
    chk("reset_outputs", int'(got), 0);
    reset_n = 1'b1;

    foreach (q[i]) begin
      @(posedge clk);
      #1;
      got = pk(lanes.gate_open, lanes.reject, timeout_err, car_entered, is_uni_car_entered,
               car_exited, is_uni_car_exited, busy);
      n_chk++;
      if (got !== q[i].exp) begin
        n_fail++;
        $display("FAIL cycle %0d outputs: got %b want %b", i, got, q[i].exp);
      end
      reset_n       = !q[i].rst;
      enable        = q[i].en;
      uni_space     = q[i].us;
      other_space   = q[i].os;
      lanes.req     = q[i].req;
      lanes.req_uni = q[i].uni;
      lanes.passed  = q[i].pas;
      if (q[i].rst) begin
        #1;
        got = pk(lanes.gate_open, lanes.reject, timeout_err, car_entered, is_uni_car_entered,
                 car_exited, is_uni_car_exited, busy);
        chk($sformatf("async_reset_cycle_%0d", i), int'(got), 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/gate_sequencer.md
GATE_SEQUENCER -- requirements
Module: gate_sequencer

Interface
REQ-001 Parameter STROBE_LEN, default 4: number of cycles a count strobe is held high.
REQ-002 Parameter OPEN_TIMEOUT, default 1000: maximum number of cycles a barrier stays open waiting for the car to pass.
REQ-003 Port: clk  in  1  single system clock; all logic is rising-edge.
REQ-004 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port: enable  in  1  parking operating; low means parking closed.
REQ-006 Port: req  in  4  level request per lane; bits 0-1 are entry lanes, bits 2-3 are exit lanes.
REQ-007 Port: req_uni  in  4  per lane, 1 means the car is a university car; sampled at grant.
REQ-008 Port: passed  in  4  per lane barrier-clear sensor, 1 means the car has passed.
REQ-009 Port: uni_space  in  1  occupancy datapath reports university space available.
REQ-010 Port: other_space  in  1  occupancy datapath reports other space available.
REQ-011 Port: car_entered, is_uni_car_entered  out  1 each  entry count strobe and its class flag.
REQ-012 Port: car_exited, is_uni_car_exited  out  1 each  exit count strobe and its class flag.
REQ-013 Port: gate_open  out  4  one-hot barrier open command per lane.
REQ-014 Port: reject  out  4  one-cycle pulse per lane: entry refused because no space.
REQ-015 Port: timeout_err  out  1  one-cycle pulse: barrier timed out with no pass.
REQ-016 Port: busy  out  1  high in every state except IDLE.

Function
REQ-017 The block SHALL serve exactly one lane at a time through FSM states IDLE, CHECK, OPEN and STROBE.
REQ-018 IDLE: if enable=1 and req is nonzero, the block SHALL grant one lane by round-robin starting at ptr, latch lane index and req_uni[lane], and go to CHECK next cycle.
REQ-019 Round-robin: ptr resets to 0; after a grant completes (any exit from OPEN, or a reject), ptr SHALL become granted lane+1 mod 4.
REQ-020 CHECK (1 cycle): for an entry lane with the latched class space flag at 0 (uni_space for uni, other_space otherwise), the block SHALL pulse reject[lane] and return to IDLE; otherwise it SHALL go to OPEN. Exit lanes always go to OPEN.
REQ-021 OPEN: gate_open[lane]=1, and timer counts from 0.
REQ-022 OPEN: passed[lane]=1 SHALL take the block to STROBE.
REQ-023 OPEN: if timer reaches OPEN_TIMEOUT-1 without a pass, the block SHALL pulse timeout_err, issue no strobe, and return to IDLE.
REQ-024 A pass and a timeout in the same cycle SHALL be treated as a pass.
REQ-025 STROBE: gate_open=0; car_entered (entry lane) or car_exited (exit lane) SHALL be high for exactly STROBE_LEN cycles, and the matching is_uni flag SHALL equal the latched class throughout.
REQ-026 After STROBE the block SHALL return to IDLE, so the strobe falls and the datapath counts on that falling edge. At least one IDLE cycle SHALL separate strobes.
REQ-027 Changes to req or req_uni after grant SHALL be ignored until IDLE.
REQ-028 passed on a non-granted lane SHALL be ignored.
REQ-029 enable=0 in any state SHALL force IDLE on the next edge, with all outputs low and ptr held.
REQ-030 The timer SHALL be wide enough to count to OPEN_TIMEOUT-1 and SHALL clear on every OPEN entry.
REQ-031 At most one bit of gate_open, and at most one strobe, SHALL be high at any time.

Reset
REQ-032 reset_n=0 SHALL asynchronously force IDLE, ptr=0, timer=0 and every output to 0; release SHALL be synchronous to clk.
REQ-033 Reset asserted mid-STROBE SHALL drop the strobe immediately; the datapath is expected to be cleared at the same time.

Structure
REQ-034 The shared package parking_pkg SHALL hold the FSM state enum, the lane index constants (ENTRY0=0, ENTRY1=1, EXIT0=2, EXIT1=3), and the STROBE_LEN/OPEN_TIMEOUT defaults.
REQ-035 Round-robin selection SHALL be a sub-module rr_arbiter4 (inputs req and ptr; outputs one-hot grant and index).

Verification
REQ-036 Entry0 req, req_uni=1, uni_space=1, passed after 5 cycles -> gate_open[0] high 5 cycles, then car_entered=1 and is_uni_car_entered=1 for 4 cycles, then busy=0.
REQ-037 Entry1 req, req_uni=0, other_space=0 -> reject[1] one-cycle pulse 2 cycles after req, no gate_open, no strobe.
REQ-038 All four req held from reset, each passing at once -> service order 0,1,2,3,0.
REQ-039 Exit2 granted, passed never asserted, OPEN_TIMEOUT=16 -> gate_open[2] high exactly 16 cycles, timeout_err pulse, no car_exited.
REQ-040 enable dropped during OPEN, and reset_n pulsed during STROBE -> next cycle all outputs 0 and state IDLE (for reset, immediately); ptr=0 after reset.
